lsu_controller: RTL

Load/store sequencing controller between the execute stage and the data-memory port. Takes the decoded size codes (MemWrite, SizeLoad) with the load/store strobes and the effective address. Runs a request/grant/response handshake with data memory, generating byte enables, lane-replicated store data and the sign- or zero-extended load result. Holds the pipeline with `stall` until the access completes, a misalignment is flagged, or a bus timeout fires.

---
 rtl/lsu_controller_if.sv | 22 ++
 rtl/lsu_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lsu_controller_if.sv
// Data-memory port of the load/store unit: request/grant/response handshake.
// The controller drives the master side; the memory (or bench) drives the slave side.
interface lsu_controller_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_controller.sv
// Load/store sequencer: decodes size and alignment, runs the req/gnt/rvalid handshake
// with data memory, extends load data and stalls the pipeline while an access is in flight.
module lsu_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LoadOp,
  input  logic             StoreOp,
  input  logic [1:0]       MemWrite,
  input  logic [2:0]       SizeLoad,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             stall,
  output logic             misalign,
  output logic             bus_err,
  output logic             load_valid,
  output logic [31:0]      rdata_out,
  lsu_controller_if.master mem
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} acc_size_t;

  state_t      state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]  sizeload_reg;
  logic [1:0]  off_reg;
  logic        bus_err_reg, load_valid_reg, req_reg, we_reg;
  logic [31:0] rdata_reg, addr_reg, wdata_reg;
  logic [3:0]  be_reg;

  logic        op_store, op_load, op_present, misaligned, idle_live, accept, timeout_hit;
  acc_size_t   size_next;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, lane, ext_next;

  // StoreOp takes priority; a store with MemWrite=00 is a no-op even if LoadOp is high.
  assign op_store   = StoreOp && (MemWrite != 2'b00);
  assign op_load    = LoadOp && !StoreOp;
  assign op_present = op_store || op_load;

  always_comb begin
    size_next = SZ_WORD;
    if (op_store) begin
      case (MemWrite)
        2'b10:   size_next = SZ_HALF;
        2'b11:   size_next = SZ_BYTE;
        default: size_next = SZ_WORD;
      endcase
    end else begin
      case (SizeLoad)
        3'b001, 3'b100: size_next = SZ_HALF;
        3'b010, 3'b011: size_next = SZ_BYTE;
        default:        size_next = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (size_next)
      SZ_HALF: begin
        be_next    = 4'b0011 << {addr[1], 1'b0};
        wdata_next = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign misaligned = ((size_next == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                      ((size_next == SZ_HALF) && addr[0]);
  // Combinational outputs are forced low while reset is held.
  assign idle_live  = rst_n && (state_reg == IDLE);
  assign misalign   = idle_live && op_present && misaligned;
  assign accept     = idle_live && op_present && !misaligned;
  assign stall      = accept || (rst_n && ((state_reg == REQ) || (state_reg == WAIT)));

  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

  assign lane = mem.mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    case (sizeload_reg)
      3'b001:  ext_next = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext_next = {16'h0000, lane[15:0]};
      3'b010:  ext_next = {{24{lane[7]}}, lane[7:0]};
      3'b011:  ext_next = {24'h000000, lane[7:0]};
      default: ext_next = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      sizeload_reg   <= '0;
      off_reg        <= '0;
      bus_err_reg    <= 1'b0;
      load_valid_reg <= 1'b0;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      rdata_reg      <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      be_reg         <= '0;
    end else begin
      bus_err_reg    <= 1'b0;
      load_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg    <= REQ;
            cnt_reg      <= '0;
            req_reg      <= 1'b1;
            we_reg       <= op_store;
            be_reg       <= be_next;
            addr_reg     <= {addr[31:2], 2'b00};
            wdata_reg    <= op_store ? wdata_next : 32'h0;
            sizeload_reg <= SizeLoad;
            off_reg      <= addr[1:0];
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (mem.mem_gnt && we_reg) begin
            state_reg <= DONE;
            req_reg   <= 1'b0;
          end else if (timeout_hit) begin
            state_reg   <= DONE;
            req_reg     <= 1'b0;
            bus_err_reg <= 1'b1;
            rdata_reg   <= '0;
          end else if (mem.mem_gnt) begin
            state_reg <= WAIT;
            req_reg   <= 1'b0;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (mem.mem_rvalid) begin
            state_reg      <= DONE;
            rdata_reg      <= ext_next;
            load_valid_reg <= 1'b1;
          end else if (timeout_hit) begin
            state_reg   <= DONE;
            bus_err_reg <= 1'b1;
            rdata_reg   <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus_err       = bus_err_reg;
  assign load_valid    = load_valid_reg;
  assign rdata_out     = rdata_reg;
  assign mem.mem_req   = req_reg;
  assign mem.mem_we    = we_reg;
  assign mem.mem_be    = be_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
endmodule
